// File: rtl/sipo_deserializer_if.sv
// Handshake and data bundle between the serial source/consumer and the
// deserializer. The master side drives the serial stream and the consumer
// ready; the slave side (the deserializer) returns the word and status.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             clr;
  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  modport master (
    output clr, sin, sin_valid, dout_ready,
    input  dout, dout_valid, bit_cnt, overrun
  );

  modport slave (
    input  clr, sin, sin_valid, dout_ready,
    output dout, dout_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer. Collects qualified serial bits into
// WIDTH-bit words and parks each completed word in a single output slot
// with a valid/ready handshake. A word that completes while the slot is
// full and not draining is dropped and raises a sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  sipo_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] dout_r;
  logic [CW-1:0]    cnt;
  logic             valid_r;
  logic             ovr_r;
  logic             done;
  logic             drain;

  // Shift register contents with the current bit appended in the chosen order.
  always_comb begin
    word_next = '0;
    if (MSB_FIRST) word_next = {shreg[WIDTH-2:0], bus.sin};
    else           word_next = {bus.sin, shreg[WIDTH-1:1]};
  end

  assign done  = bus.sin_valid && (cnt == LAST_CNT);
  assign drain = valid_r && bus.dout_ready;

  // Bit collection: shift on every qualified bit, wrap the count on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (bus.clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (bus.sin_valid) begin
      shreg <= word_next;
      cnt   <= done ? '0 : cnt + 1'b1;
    end
  end

  // Output slot: load when free or draining this edge, else flag the lost word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r  <= '0;
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else if (bus.clr) begin
      dout_r  <= '0;
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else if (done) begin
      if (!valid_r || drain) begin
        dout_r  <= word_next;
        valid_r <= 1'b1;
      end else begin
        ovr_r <= 1'b1;
      end
    end else if (drain) begin
      valid_r <= 1'b0;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = valid_r;
  assign bus.bit_cnt    = cnt;
  assign bus.overrun    = ovr_r;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: one MSB-first and one LSB-first instance
// driven with the same serial stream; drained words are checked against
// per-instance expected-word queues, status outputs checked directly.
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(4)) bus_m ();
  sipo_deserializer_if #(.WIDTH(4)) bus_l ();

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] q_m[$];
  logic [3:0] q_l[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic c, input logic s, input logic sv);
    bus_m.clr = c;  bus_m.sin = s;  bus_m.sin_valid = sv;  bus_m.dout_ready = rdy;
    bus_l.clr = c;  bus_l.sin = s;  bus_l.sin_valid = sv;  bus_l.dout_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // w[3] is sent first; leaves sin_valid high so words can run back to back
  task automatic send_word(input logic [3:0] w, input bit push);
    if (push) begin
      q_m.push_back(w);
      q_l.push_back({w[0], w[1], w[2], w[3]});
    end
    for (int i = 3; i >= 0; i--) begin
      set_in(1'b0, w[i], 1'b1);
      step();
    end
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0);
    step();
  endtask

  // Scoreboard: compare the slot contents on every edge that will consume it
  always @(negedge clk) begin
    if (!rst && !bus_m.clr && bus_m.dout_valid && bus_m.dout_ready) begin
      if (q_m.size() == 0) chk("msb_unexpected_word", 32'(bus_m.dout), 32'hDEAD);
      else chk("msb_word", 32'(bus_m.dout), 32'(q_m.pop_front()));
    end
    if (!rst && !bus_l.clr && bus_l.dout_valid && bus_l.dout_ready) begin
      if (q_l.size() == 0) chk("lsb_unexpected_word", 32'(bus_l.dout), 32'hDEAD);
      else chk("lsb_word", 32'(bus_l.dout), 32'(q_l.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] gap_bits;
    logic [2:0] gap_cnt [8];
    gap_bits = 4'b1100;
    gap_cnt  = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0};

    set_in(1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_dout",    32'(bus_m.dout), 0);
    chk("rst_valid",   32'(bus_m.dout_valid), 0);
    chk("rst_cnt",     32'(bus_m.bit_cnt), 0);
    chk("rst_overrun", 32'(bus_m.overrun), 0);
    #9 rst = 1'b0;
    step();

    // single word, consumer not ready
    rdy = 1'b0;
    send_word(4'b1011, 1'b1);
    set_in(1'b0, 1'b0, 1'b0);
    chk("single_msb_dout", 32'(bus_m.dout), 32'hB);
    chk("single_lsb_dout", 32'(bus_l.dout), 32'hD);
    chk("single_valid",    32'(bus_m.dout_valid), 1);
    chk("single_cnt",      32'(bus_m.bit_cnt), 0);
    rdy = 1'b1;
    idle();
    chk("drain_valid", 32'(bus_m.dout_valid), 0);
    chk("drain_hold",  32'(bus_m.dout), 32'hB);
    rdy = 1'b0;

    // bits separated by idle cycles: count must hold through the gaps
    q_m.push_back(4'b1100);
    q_l.push_back(4'b0011);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, gap_bits[3-i], 1'b1);
      step();
      chk("gap_cnt_bit", 32'(bus_l.bit_cnt), 32'(gap_cnt[2*i]));
      idle();
      chk("gap_cnt_idle", 32'(bus_l.bit_cnt), 32'(gap_cnt[2*i+1]));
    end
    chk("gap_lsb_dout", 32'(bus_l.dout), 32'h3);
    chk("gap_msb_dout", 32'(bus_m.dout), 32'hC);
    rdy = 1'b1;
    idle();
    rdy = 1'b0;

    // asynchronous reset mid-cycle, mid-word
    set_in(1'b0, 1'b1, 1'b1); step();
    set_in(1'b0, 1'b0, 1'b1); step();
    chk("partial_cnt", 32'(bus_m.bit_cnt), 2);
    set_in(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout",  32'(bus_m.dout), 0);
    chk("arst_ldout", 32'(bus_l.dout), 0);
    chk("arst_cnt",   32'(bus_m.bit_cnt), 0);
    chk("arst_valid", 32'(bus_m.dout_valid), 0);
    #1 rst = 1'b0;
    step();
    send_word(4'b0110, 1'b1);
    set_in(1'b0, 1'b0, 1'b0);
    chk("post_rst_dout", 32'(bus_m.dout), 32'h6);
    rdy = 1'b1;
    idle();

    // back-to-back words with continuous drain
    send_word(4'b1010, 1'b1);
    send_word(4'b0110, 1'b1);
    idle();
    chk("b2b_valid",   32'(bus_m.dout_valid), 0);
    chk("b2b_overrun", 32'(bus_m.overrun), 0);
    chk("b2b_l_ovr",   32'(bus_l.overrun), 0);

    // overrun: second word arrives while the slot is still full
    rdy = 1'b0;
    send_word(4'b1111, 1'b0);
    send_word(4'b0001, 1'b0);
    idle();
    chk("ovr_dout",  32'(bus_m.dout), 32'hF);
    chk("ovr_flag",  32'(bus_m.overrun), 1);
    chk("ovr_lflag", 32'(bus_l.overrun), 1);
    chk("ovr_valid", 32'(bus_m.dout_valid), 1);
    chk("ovr_cnt",   32'(bus_m.bit_cnt), 0);
    set_in(1'b1, 1'b1, 1'b1);
    step();
    set_in(1'b0, 1'b0, 1'b0);
    chk("clr_valid",   32'(bus_m.dout_valid), 0);
    chk("clr_overrun", 32'(bus_m.overrun), 0);
    chk("clr_dout",    32'(bus_m.dout), 0);
    chk("clr_cnt",     32'(bus_m.bit_cnt), 0);

    // collection continues normally after clear
    rdy = 1'b1;
    send_word(4'b0011, 1'b1);
    idle();
    idle();

    chk("msb_queue_empty", 32'(q_m.size()), 0);
    chk("lsb_queue_empty", 32'(q_l.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
